// File: rtl/or_1bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : or_1bit_arbiter
// Purpose  : Round-robin scheduler sharing one 1-bit OR datapath between
//            NUM_REQ requesters, with valid/ready request and response sides.
// Revision : 1.0  initial release
// ============================================================================
module or_1bit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_data,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [ID_W-1:0]  c_last_id = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_a;
  logic               r_b;
  logic               r_rsp_data;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_cand;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_rsp_valid;
  logic               w_or_result;

  // Scan from the round-robin pointer; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Gated by rst_n so nothing is offered while the block is held in reset.
  always_comb begin
    w_req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      w_req_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    if (r_state == S_RESP) begin
      w_rsp_valid[r_grant_id] = 1'b1;
    end
  end

  // Shared 1-bit OR datapath, fed only from the latched operand pair.
  assign w_or_result = r_a | r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_rsp_data <= 1'b0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a        <= req_a[w_winner];
            r_b        <= req_b[w_winner];
            r_grant_id <= w_winner;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data <= w_or_result;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[r_grant_id]) begin
            r_rr_ptr <= (r_grant_id == c_last_id) ? '0 : r_grant_id + ID_W'(1);
            if (r_op_count != c_cnt_max) begin
              r_op_count <= r_op_count + CNT_W'(1);
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != S_IDLE);
  assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_or_1bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_or_1bit_arbiter
// Purpose  : Scoreboard bench for or_1bit_arbiter: transaction-level model
//            predicts grants, monitor checks every response against a queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_or_1bit_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_a = '0;
  logic [N-1:0]   req_b = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic           rsp_data;
  logic [N-1:0]   rsp_ready = '0;
  logic [1:0]     grant_id;
  logic           busy;
  logic [CNT_W-1:0] op_count;

  or_1bit_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .grant_id(grant_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       d;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Transaction-level model: who owns the datapath, where the rotation starts.
  int m_ptr = 0, m_owner = -1, m_lat = 0, m_cnt = 0, m_gid = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [N-1:0] r);
    int win;
    int exp_rdy;
    logic [1:0] wi;
    @(posedge clk);
    #1;
    req_valid = v; req_a = a; req_b = b; rsp_ready = r;
    @(negedge clk);
    win = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_rdy = (win >= 0) ? (1 << win) : 0;
    chk("req_ready", int'(req_ready), exp_rdy);
    chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("op_count", int'(op_count), m_cnt);
    chk("grant_id", int'(grant_id), m_gid);
    if (m_owner < 0) begin
      if (win >= 0) begin
        wi = 2'(win);
        sbq.push_back('{id: wi, d: a[wi] | b[wi]});
        m_owner = win; m_lat = 0; m_gid = win;
      end
    end else if (m_lat == 0) begin
      m_lat = 1;
    end else if (r[m_owner]) begin
      if (m_cnt < CMAX) m_cnt++;
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    req_valid = '1; rsp_ready = '0; rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", int'(rsp_valid), 0);
    chk("rst op_count", int'(op_count), 0);
    chk("rst grant_id", int'(grant_id), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst req_ready", int'(req_ready), 0);
    chk("rst rsp_data", int'(rsp_data), 0);
    sbq.delete();
    m_ptr = 0; m_owner = -1; m_lat = 0; m_cnt = 0; m_gid = 0;
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: pops one expectation per response and checks it every cycle it is held.
  initial begin
    exp_t cur;
    bit   have_cur;
    logic [N-1:0] oh;
    have_cur = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 1'b0;
      end else if (mon_en && rsp_valid != '0) begin
        if (!have_cur) begin
          if (sbq.size() == 0) begin
            chk("unexpected rsp_valid", int'(rsp_valid), 0);
          end else begin
            cur = sbq.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          oh = N'(1) << cur.id;
          chk("rsp_valid", int'(rsp_valid), int'(oh));
          chk("rsp_data", int'(rsp_data), int'(cur.d));
          chk("rsp grant_id", int'(grant_id), int'(cur.id));
          if (rsp_ready[cur.id]) have_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    do_reset();

    // Single request from requester 0: 1|0.
    step(4'b0001, 4'b0001, 4'b0000, 4'b1111);
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // All four valid: operands (0,0),(1,0),(0,1),(1,1) served in rotation.
    do_reset();
    repeat (12) step(4'b1111, 4'b1010, 4'b1100, 4'b1111);
    repeat (3) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // Backpressure on requester 2 while requester 0 waits.
    do_reset();
    repeat (2) step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    repeat (10) step(4'b0101, 4'b0001, 4'b0000, 4'b1011);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0100);
    repeat (4) step(4'b0001, 4'b0001, 4'b0000, 4'b1111);
    repeat (2) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // Fairness wrap: pointer at 3, requesters 3 and 0 valid.
    do_reset();
    repeat (3) step(4'b0100, 4'b0000, 4'b0000, 4'b1111);
    repeat (6) step(4'b1001, 4'b1000, 4'b0001, 4'b1111);
    repeat (2) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // Reset while requester 1 is in its response phase.
    do_reset();
    repeat (3) step(4'b0010, 4'b0010, 4'b0000, 4'b0000);
    chk("pre-reset rsp_valid", int'(rsp_valid), 2);
    do_reset();
    repeat (5) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // Randomised traffic; the narrow counter also reaches saturation here.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, 4'b1111);
    chk("scoreboard drained", sbq.size(), 0);
    chk("op_count saturated", int'(op_count), CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
